w0rm_alu_writeback: RTL and testbench

- Downstream stage of the multi-cycle ALU units (shifts unit first); consumes result/result_valid/result_flags and turns them into register-file write-backs.
- The ALU cannot be stalled and carries no destination, so this block holds a destination-tag queue filled at issue time and pairs each result with the oldest outstanding tag.
- Buffers paired results and presents them to the register file on a valid/ready port; maintains the architectural flags register.

---
 rtl/w0rm_core_pkg.sv | 27 ++
 rtl/w0rm_sync_fifo.sv | 46 ++++
 rtl/w0rm_alu_writeback.sv | 121 ++++++++++++
 tb/tb_w0rm_alu_writeback.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/w0rm_core_pkg.sv
// Shared core definitions: flag vector layout and the write-back record layouts
// for the default core configuration (4-bit register address, 32-bit data).
package w0rm_core_pkg;

  localparam int FLAGS_WIDTH = 4;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  localparam int CORE_REG_ADDR_WIDTH = 4;
  localparam int CORE_DATA_WIDTH     = 32;

  typedef struct packed {
    logic [CORE_REG_ADDR_WIDTH-1:0] dest;
    logic                           set_flags;
  } tag_t;

  typedef struct packed {
    logic [CORE_REG_ADDR_WIDTH-1:0] dest;
    logic                           set_flags;
    logic [FLAGS_WIDTH-1:0]         flags;
    logic [CORE_DATA_WIDTH-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/w0rm_sync_fifo.sv
// Single-clock FIFO with extra-MSB wrap pointers; head is a combinational read
// of the oldest entry. Push while full is accepted only when a pop frees a slot.
module w0rm_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is data only; validity is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/w0rm_alu_writeback.sv
// Pairs ALU results with destination tags captured at issue time, buffers the
// paired entries for the register file and maintains the architectural flags.
module w0rm_alu_writeback #(
  parameter int DATA_WIDTH     = 32,
  parameter int FLAGS_WIDTH    = w0rm_core_pkg::FLAGS_WIDTH,
  parameter int REG_ADDR_WIDTH = 4,
  parameter int DEPTH          = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      issue_valid,
  output logic                      issue_ready,
  input  logic [REG_ADDR_WIDTH-1:0] issue_dest,
  input  logic                      issue_set_flags,
  input  logic                      alu_result_valid,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  input  logic [FLAGS_WIDTH-1:0]    alu_result_flags,
  output logic                      wb_valid,
  input  logic                      wb_ready,
  output logic [REG_ADDR_WIDTH-1:0] wb_addr,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic [FLAGS_WIDTH-1:0]    flags,
  output logic                      protocol_error
);

  import w0rm_core_pkg::*;

  localparam int CW = $clog2(DEPTH + 1);

  // Same field order as the package records, sized by this instance's parameters.
  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] dest;
    logic                      set_flags;
  } tag_rec_t;

  typedef struct packed {
    logic [REG_ADDR_WIDTH-1:0] dest;
    logic                      set_flags;
    logic [FLAGS_WIDTH-1:0]    flags;
    logic [DATA_WIDTH-1:0]     data;
  } wb_rec_t;

  logic [CW-1:0] count;
  tag_rec_t      tag_in;
  tag_rec_t      tag_head;
  wb_rec_t       res_in;
  wb_rec_t       res_head;
  logic          tag_empty;
  logic          res_empty;
  logic          unused_tag_full;
  logic          unused_res_full;
  logic          issue_fire;
  logic          tag_pop;
  logic          wb_fire;

  assign issue_ready = rst_n & (count < CW'(DEPTH));
  assign issue_fire  = issue_valid & issue_ready;
  assign tag_pop     = alu_result_valid & ~tag_empty;
  assign wb_valid    = ~res_empty;
  assign wb_fire     = wb_valid & wb_ready;

  assign tag_in = '{dest: issue_dest, set_flags: issue_set_flags};
  assign res_in = '{dest: tag_head.dest, set_flags: tag_head.set_flags,
                    flags: alu_result_flags, data: alu_result};

  // Queue storage is not reset, so the port is masked to zero when idle.
  assign wb_addr = wb_valid ? res_head.dest : '0;
  assign wb_data = wb_valid ? res_head.data : '0;

  w0rm_sync_fifo #(
    .WIDTH($bits(tag_rec_t)),
    .DEPTH(DEPTH)
  ) u_tag_q (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (issue_fire),
    .push_data(tag_in),
    .pop      (tag_pop),
    .full     (unused_tag_full),
    .empty    (tag_empty),
    .head     (tag_head)
  );

  // Count bounds occupancy, so this queue can never refuse a paired result.
  w0rm_sync_fifo #(
    .WIDTH($bits(wb_rec_t)),
    .DEPTH(DEPTH)
  ) u_res_q (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (tag_pop),
    .push_data(res_in),
    .pop      (wb_ready),
    .full     (unused_res_full),
    .empty    (res_empty),
    .head     (res_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({issue_fire, wb_fire})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags          <= '0;
      protocol_error <= 1'b0;
    end else begin
      if (wb_fire && res_head.set_flags) flags <= res_head.flags;
      if (alu_result_valid && tag_empty) protocol_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_w0rm_alu_writeback.sv
// Randomised and directed bench for w0rm_alu_writeback against a queue-based
// reference model of tag pairing, write-back retirement and flags.
module tb_w0rm_alu_writeback;

  localparam int DW    = 8;
  localparam int FW    = 4;
  localparam int AW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic [AW-1:0] issue_dest = '0;
  logic          issue_set_flags = 1'b0;
  logic          alu_result_valid = 1'b0;
  logic [DW-1:0] alu_result = '0;
  logic [FW-1:0] alu_result_flags = '0;
  logic          wb_valid;
  logic          wb_ready = 1'b0;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [FW-1:0] flags;
  logic          protocol_error;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  w0rm_alu_writeback #(
    .DATA_WIDTH(DW), .FLAGS_WIDTH(FW), .REG_ADDR_WIDTH(AW), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_dest(issue_dest), .issue_set_flags(issue_set_flags),
    .alu_result_valid(alu_result_valid), .alu_result(alu_result),
    .alu_result_flags(alu_result_flags),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .flags(flags), .protocol_error(protocol_error)
  );

  typedef struct {
    logic [AW-1:0] dest;
    logic          sf;
  } tag_m_t;

  typedef struct {
    logic [AW-1:0] dest;
    logic          sf;
    logic [FW-1:0] fl;
    logic [DW-1:0] data;
  } ent_m_t;

  tag_m_t        m_tags[$];
  ent_m_t        m_res[$];
  logic [FW-1:0] m_flags = '0;
  logic          m_perr = 1'b0;

  function automatic logic exp_valid();
    return m_res.size() > 0;
  endfunction

  function automatic logic [AW-1:0] exp_addr();
    return (m_res.size() > 0) ? m_res[0].dest : '0;
  endfunction

  function automatic logic [DW-1:0] exp_data();
    return (m_res.size() > 0) ? m_res[0].data : '0;
  endfunction

  function automatic logic exp_ready();
    return (m_tags.size() + m_res.size()) < DEPTH;
  endfunction

  task automatic model_clear();
    m_tags.delete();
    m_res.delete();
    m_flags = '0;
    m_perr  = 1'b0;
  endtask

  // Applies the transfer rules to the inputs currently driven, as of the coming edge.
  task automatic model_edge();
    int cnt;
    bit iss_ok, res_ok, wb_ok;
    cnt    = m_tags.size() + m_res.size();
    iss_ok = issue_valid && (cnt < DEPTH);
    res_ok = alu_result_valid && (m_tags.size() > 0);
    wb_ok  = wb_ready && (m_res.size() > 0);
    if (wb_ok) begin
      ent_m_t e;
      e = m_res.pop_front();
      if (e.sf) m_flags = e.fl;
    end
    if (res_ok) begin
      tag_m_t t;
      ent_m_t n;
      t = m_tags.pop_front();
      n.dest = t.dest;
      n.sf   = t.sf;
      n.fl   = alu_result_flags;
      n.data = alu_result;
      m_res.push_back(n);
    end else if (alu_result_valid) begin
      m_perr = 1'b1;
    end
    if (iss_ok) begin
      tag_m_t t;
      t.dest = issue_dest;
      t.sf   = issue_set_flags;
      m_tags.push_back(t);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL reset_issue_ready_low got=%0b want=0", issue_ready); end
    @(posedge clk); @(posedge clk); #1;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%0b want=0", wb_valid); end
    checks++; if (flags !== 4'b0000) begin failures++; $display("FAIL reset_flags got=%b want=0000", flags); end
    checks++; if (protocol_error !== 1'b0) begin failures++; $display("FAIL reset_perr got=%0b want=0", protocol_error); end
    checks++; if (wb_addr !== '0 || wb_data !== '0) begin failures++; $display("FAIL reset_wb_port got=%h/%h want=0/0", wb_addr, wb_data); end
    rst_n = 1'b1;
    model_clear();
    #1;
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL reset_issue_ready_high got=%0b want=1", issue_ready); end
  endtask

  task automatic test_single_op();
    wb_ready = 1'b1;
    issue_valid = 1'b1; issue_dest = 4'd3; issue_set_flags = 1'b1;
    step();
    issue_valid = 1'b0;
    step();
    alu_result_valid = 1'b1; alu_result = 8'h80; alu_result_flags = 4'b0010;
    step();
    alu_result_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1) begin failures++; $display("FAIL single_wb_valid got=%0b want=1", wb_valid); end
    checks++; if (wb_addr !== 4'd3) begin failures++; $display("FAIL single_wb_addr got=%0d want=3", wb_addr); end
    checks++; if (wb_data !== 8'h80) begin failures++; $display("FAIL single_wb_data got=%h want=80", wb_data); end
    step();
    checks++; if (flags !== 4'b0010) begin failures++; $display("FAIL single_flags got=%b want=0010", flags); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL single_wb_drained got=%0b want=0", wb_valid); end
  endtask

  task automatic test_backpressure();
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1; issue_dest = AW'(5 + i); issue_set_flags = 1'b0;
      step();
    end
    issue_valid = 1'b0;
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL bp_issue_ready_full got=%0b want=0", issue_ready); end
    for (int i = 0; i < 4; i++) begin
      alu_result_valid = 1'b1; alu_result = DW'(i + 1); alu_result_flags = FW'($urandom);
      step();
    end
    alu_result_valid = 1'b0;
    step();
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 4'd5 || wb_data !== 8'h01) begin
      failures++; $display("FAIL bp_head_stable got=%0b/%0d/%h want=1/5/01", wb_valid, wb_addr, wb_data);
    end
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (wb_addr !== AW'(5 + i) || wb_data !== DW'(i + 1)) begin
        failures++; $display("FAIL bp_order_%0d got=%0d/%h want=%0d/%h", i, wb_addr, wb_data, 5 + i, i + 1);
      end
      step();
      if (i == 0) begin
        checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL bp_issue_ready_return got=%0b want=1", issue_ready); end
      end
    end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL bp_drained got=%0b want=0", wb_valid); end
    checks++; if (flags !== 4'b0010) begin failures++; $display("FAIL bp_flags_hold got=%b want=0010", flags); end
  endtask

  task automatic test_flags_gating();
    wb_ready = 1'b1;
    issue_valid = 1'b1; issue_dest = 4'd9; issue_set_flags = 1'b0;
    step();
    issue_valid = 1'b0;
    alu_result_valid = 1'b1; alu_result = 8'h5A; alu_result_flags = 4'b1111;
    step();
    alu_result_valid = 1'b0;
    checks++; if (wb_addr !== 4'd9 || wb_data !== 8'h5A) begin failures++; $display("FAIL gate_wb got=%0d/%h want=9/5a", wb_addr, wb_data); end
    step();
    checks++; if (flags !== 4'b0010) begin failures++; $display("FAIL gate_flags got=%b want=0010", flags); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL gate_written got=%0b want=0", wb_valid); end
  endtask

  task automatic test_orphan();
    wb_ready = 1'b1;
    issue_valid = 1'b1; issue_dest = 4'd2; issue_set_flags = 1'b1;
    alu_result_valid = 1'b1; alu_result = 8'hEE; alu_result_flags = 4'b0100;
    step();
    issue_valid = 1'b0; alu_result_valid = 1'b0;
    checks++; if (protocol_error !== 1'b1) begin failures++; $display("FAIL orphan_perr got=%0b want=1", protocol_error); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL orphan_dropped got=%0b want=0", wb_valid); end
    step();
    alu_result_valid = 1'b1; alu_result = 8'h11; alu_result_flags = 4'b1000;
    step();
    alu_result_valid = 1'b0;
    checks++; if (wb_addr !== 4'd2 || wb_data !== 8'h11) begin failures++; $display("FAIL orphan_tag_kept got=%0d/%h want=2/11", wb_addr, wb_data); end
    step();
    checks++; if (flags !== 4'b1000) begin failures++; $display("FAIL orphan_flags got=%b want=1000", flags); end
    checks++; if (protocol_error !== 1'b1) begin failures++; $display("FAIL orphan_sticky got=%0b want=1", protocol_error); end
  endtask

  task automatic test_simultaneous();
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1; issue_dest = AW'(10 + i); issue_set_flags = 1'b1;
      step();
    end
    issue_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alu_result_valid = 1'b1; alu_result = DW'($urandom); alu_result_flags = FW'($urandom);
      step();
    end
    alu_result_valid = 1'b0;
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL sim_full got=%0b want=0", issue_ready); end
    wb_ready = 1'b1; issue_valid = 1'b1; issue_dest = 4'd14; issue_set_flags = 1'b0;
    step();
    checks++; if (issue_ready !== exp_ready()) begin failures++; $display("FAIL sim_pop_only got=%0b want=%0b", issue_ready, exp_ready()); end
    issue_dest = 4'd15;
    step();
    checks++; if (issue_ready !== 1'b1 || m_tags.size() + m_res.size() != 3) begin
      failures++; $display("FAIL sim_both got=%0b want=1", issue_ready);
    end
    wb_ready = 1'b0; issue_dest = 4'd1;
    step();
    issue_valid = 1'b0;
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL sim_refill got=%0b want=0", issue_ready); end
    wb_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      alu_result_valid = (m_tags.size() > 0); alu_result = DW'($urandom); alu_result_flags = FW'($urandom);
      checks++; if (wb_valid !== exp_valid() || wb_addr !== exp_addr() || wb_data !== exp_data()) begin
        failures++; $display("FAIL sim_drain_%0d got=%0b/%0d/%h want=%0b/%0d/%h", c, wb_valid, wb_addr, wb_data, exp_valid(), exp_addr(), exp_data());
      end
      step();
    end
    alu_result_valid = 1'b0;
    checks++; if (wb_valid !== 1'b0 || m_res.size() != 0 || m_tags.size() != 0) begin
      failures++; $display("FAIL sim_drain_complete got=%0b want=0", wb_valid);
    end
    checks++; if (flags !== m_flags) begin failures++; $display("FAIL sim_flags got=%b want=%b", flags, m_flags); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      issue_valid      = ($urandom_range(0, 1) == 1);
      issue_dest       = AW'($urandom);
      issue_set_flags  = ($urandom_range(0, 1) == 1);
      alu_result_valid = (m_tags.size() > 0) && ($urandom_range(0, 2) != 0);
      alu_result       = DW'($urandom);
      alu_result_flags = FW'($urandom);
      wb_ready         = ($urandom_range(0, 3) != 0);
      step();
      checks++; if (wb_valid !== exp_valid() || wb_addr !== exp_addr() || wb_data !== exp_data()) begin
        failures++; $display("FAIL rand_wb_%0d got=%0b/%0d/%h want=%0b/%0d/%h", c, wb_valid, wb_addr, wb_data, exp_valid(), exp_addr(), exp_data());
      end
      checks++; if (flags !== m_flags || protocol_error !== m_perr) begin
        failures++; $display("FAIL rand_state_%0d got=%b/%0b want=%b/%0b", c, flags, protocol_error, m_flags, m_perr);
      end
      checks++; if (issue_ready !== exp_ready()) begin
        failures++; $display("FAIL rand_ready_%0d got=%0b want=%0b", c, issue_ready, exp_ready());
      end
    end
    issue_valid = 1'b0; alu_result_valid = 1'b0;
  endtask

  task automatic test_reset_midstream();
    while (m_tags.size() > 0) begin
      alu_result_valid = 1'b1; wb_ready = 1'b1;
      step();
    end
    alu_result_valid = 1'b0; wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; issue_dest = AW'(i); issue_set_flags = 1'b1;
      alu_result_valid = (i == 1); alu_result = 8'h77; alu_result_flags = 4'b0101;
      step();
    end
    issue_valid = 1'b0; alu_result_valid = 1'b0;
    checks++; if (wb_valid !== exp_valid()) begin failures++; $display("FAIL mid_before got=%0b want=%0b", wb_valid, exp_valid()); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (wb_valid !== 1'b0 || flags !== 4'b0000 || protocol_error !== 1'b0) begin
      failures++; $display("FAIL mid_async got=%0b/%b/%0b want=0/0000/0", wb_valid, flags, protocol_error);
    end
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL mid_ready_in_reset got=%0b want=0", issue_ready); end
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++; if (issue_ready !== 1'b1 || wb_valid !== 1'b0) begin
      failures++; $display("FAIL mid_release got=%0b/%0b want=1/0", issue_ready, wb_valid);
    end
    for (int i = 0; i < 4; i++) begin
      issue_valid = 1'b1; issue_dest = AW'(i);
      step();
      checks++; if (issue_ready !== ((i < 3) ? 1'b1 : 1'b0)) begin
        failures++; $display("FAIL mid_count_%0d got=%0b want=%0b", i, issue_ready, (i < 3));
      end
    end
    issue_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_backpressure();
    test_flags_gating();
    test_orphan();
    test_simultaneous();
    test_random();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
